sid_write_scheduler: RTL and testbench

SID_WRITE_SCHEDULER -- requirements
Module: sid_write_scheduler

---
 rtl/sid_write_scheduler.sv | 153 +++++++++++++++
 tb/tb_sid_write_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_write_scheduler.sv
// sid_write_scheduler: two-port register write scheduler with
// per-port FIFOs, clkEn-paced single issue and shadow readback.
module sid_write_scheduler #(
  parameter int FIFO_DEPTH    = 4,
  parameter bit HOST_PRIORITY = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clkEn,
  input  logic       iHostValid,
  output logic       oHostReady,
  input  logic [4:0] iHostAddr,
  input  logic [7:0] iHostData,
  input  logic       iSeqValid,
  output logic       oSeqReady,
  input  logic [4:0] iSeqAddr,
  input  logic [7:0] iSeqData,
  output logic       oWE,
  output logic [4:0] oAddr,
  output logic [7:0] oData,
  input  logic [4:0] iRdAddr,
  output logic [7:0] oRdData,
  output logic       oBusy,
  output logic [7:0] oDropCount
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [4:0] MAX_ADDR = 5'h18;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  // Port 0 is host, port 1 is sequencer.
  logic [12:0]   mem_q [2][FIFO_DEPTH];
  logic [12:0]   mem_d [2][FIFO_DEPTH];
  logic [AW-1:0] rp_q [2];
  logic [AW-1:0] rp_d [2];
  logic [AW-1:0] wp_q [2];
  logic [AW-1:0] wp_d [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [7:0]    shadow_q [25];
  logic [7:0]    shadow_d [25];

  logic       last_seq_q, last_seq_d;
  logic       we_q, we_d;
  logic [4:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] rd_q, rd_d;
  logic [7:0] drop_q, drop_d;

  logic [1:0]  vld, rdy, push, pop, ne;
  logic [12:0] din [2];
  logic [1:0]  ndrop;
  logic [8:0]  drop_sum;
  logic        issue, gnt_seq;
  logic [12:0] head;

  // Handshake: accept when not full, split legal writes from drops.
  always_comb begin
    vld    = {iSeqValid, iHostValid};
    din[0] = {iHostAddr, iHostData};
    din[1] = {iSeqAddr, iSeqData};
    ndrop  = '0;
    ne     = '0;
    rdy    = '0;
    push   = '0;
    for (int p = 0; p < 2; p++) begin
      ne[p]   = cnt_q[p] != '0;
      rdy[p]  = ~rst & (cnt_q[p] != FULL_CNT);
      push[p] = vld[p] & rdy[p]
              & (din[p][12:8] <= MAX_ADDR);
      if (vld[p] & rdy[p] & (din[p][12:8] > MAX_ADDR))
        ndrop = ndrop + 2'd1;
    end
  end

  // Arbitration on registered FIFO state, only on clkEn.
  always_comb begin
    issue   = clkEn & ~rst & (|ne);
    gnt_seq = ne[1] & (~ne[0]
            | (~HOST_PRIORITY & ~last_seq_q));
    pop          = '0;
    pop[gnt_seq] = issue;
    head = mem_q[gnt_seq][rp_q[gnt_seq]];
  end

  // Next-state for FIFOs, issue bus, shadow and counters.
  always_comb begin
    mem_d = mem_q;
    for (int p = 0; p < 2; p++) begin
      if (push[p])
        mem_d[p][wp_q[p]] = din[p];
      wp_d[p]  = wp_q[p] + AW'(push[p]);
      rp_d[p]  = rp_q[p] + AW'(pop[p]);
      cnt_d[p] = cnt_q[p] + CW'(push[p])
               - CW'(pop[p]);
    end
    last_seq_d = issue ? gnt_seq : last_seq_q;
    we_d   = issue;
    addr_d = issue ? head[12:8] : addr_q;
    data_d = issue ? head[7:0] : data_q;
    shadow_d = shadow_q;
    if (we_q)
      shadow_d[addr_q] = data_q;
    rd_d = (iRdAddr <= MAX_ADDR)
         ? shadow_q[iRdAddr] : 8'h00;
    drop_sum = {1'b0, drop_q} + 9'(ndrop);
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < FIFO_DEPTH; i++)
          mem_q[p][i] <= '0;
        rp_q[p]  <= '0;
        wp_q[p]  <= '0;
        cnt_q[p] <= '0;
      end
      for (int i = 0; i < 25; i++)
        shadow_q[i] <= '0;
      last_seq_q <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rd_q       <= '0;
      drop_q     <= '0;
    end else begin
      mem_q      <= mem_d;
      rp_q       <= rp_d;
      wp_q       <= wp_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      last_seq_q <= last_seq_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rd_q       <= rd_d;
      drop_q     <= drop_d;
    end
  end

  assign oHostReady = rdy[0];
  assign oSeqReady  = rdy[1];
  assign oWE        = we_q;
  assign oAddr      = addr_q;
  assign oData      = data_q;
  assign oRdData    = rd_q;
  assign oDropCount = drop_q;
  assign oBusy      = ~rst & ((|ne) | we_q);

endmodule

// File: tb/tb_sid_write_scheduler.sv
// tb_sid_write_scheduler: round-robin and host-priority instances
// driven together, checked against a queue-based model.
module tb_sid_write_scheduler;

  localparam int FD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b0;
  logic hv = 1'b0;
  logic sv = 1'b0;
  logic [4:0] ha = '0, sa = '0, rda = '0;
  logic [7:0] hd = '0, sd = '0;

  logic hr [2], sr [2], we [2], busy [2];
  logic [4:0] ad [2];
  logic [7:0] dt [2], rd [2], dc [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sid_write_scheduler #(.FIFO_DEPTH(FD), .HOST_PRIORITY(1'b0)) u0 (
    .clk(clk), .rst(rst), .clkEn(ce),
    .iHostValid(hv), .oHostReady(hr[0]),
    .iHostAddr(ha), .iHostData(hd),
    .iSeqValid(sv), .oSeqReady(sr[0]),
    .iSeqAddr(sa), .iSeqData(sd),
    .oWE(we[0]), .oAddr(ad[0]), .oData(dt[0]),
    .iRdAddr(rda), .oRdData(rd[0]),
    .oBusy(busy[0]), .oDropCount(dc[0])
  );

  sid_write_scheduler #(.FIFO_DEPTH(FD), .HOST_PRIORITY(1'b1)) u1 (
    .clk(clk), .rst(rst), .clkEn(ce),
    .iHostValid(hv), .oHostReady(hr[1]),
    .iHostAddr(ha), .iHostData(hd),
    .iSeqValid(sv), .oSeqReady(sr[1]),
    .iSeqAddr(sa), .iSeqData(sd),
    .oWE(we[1]), .oAddr(ad[1]), .oData(dt[1]),
    .iRdAddr(rda), .oRdData(rd[1]),
    .oBusy(busy[1]), .oDropCount(dc[1])
  );

  // Model: queue 2*d = host, 2*d+1 = sequencer of instance d.
  typedef logic [12:0] ent_q_t [$];
  ent_q_t mq [4];
  logic [7:0] msh [2][25];
  bit m_last [2];
  bit m_we [2];
  logic [4:0] m_ad [2];
  logic [7:0] m_dt [2], m_rd [2], m_dc [2];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      bit hacc, sacc, gs;
      int nd, t;
      logic [12:0] e;
      if (rst) begin
        mq[2*d].delete();
        mq[2*d+1].delete();
        for (int i = 0; i < 25; i++) msh[d][i] = 8'h00;
        m_last[d] = 1'b1;
        m_we[d] = 1'b0;
        m_ad[d] = '0;
        m_dt[d] = '0;
        m_rd[d] = '0;
        m_dc[d] = '0;
        continue;
      end
      hacc = hv && (mq[2*d].size() < FD);
      sacc = sv && (mq[2*d+1].size() < FD);
      m_rd[d] = (rda <= 5'd24) ? msh[d][rda] : 8'h00;
      if (m_we[d]) msh[d][m_ad[d]] = m_dt[d];
      if (ce && (mq[2*d].size() > 0 || mq[2*d+1].size() > 0)) begin
        if (mq[2*d].size() == 0) gs = 1'b1;
        else if (mq[2*d+1].size() == 0) gs = 1'b0;
        else if (d == 1) gs = 1'b0;
        else gs = !m_last[d];
        e = mq[2*d + int'(gs)].pop_front();
        m_last[d] = gs;
        m_we[d] = 1'b1;
        m_ad[d] = e[12:8];
        m_dt[d] = e[7:0];
      end else begin
        m_we[d] = 1'b0;
      end
      nd = 0;
      if (hacc) begin
        if (ha <= 5'd24) mq[2*d].push_back({ha, hd});
        else nd++;
      end
      if (sacc) begin
        if (sa <= 5'd24) mq[2*d+1].push_back({sa, sd});
        else nd++;
      end
      t = int'(m_dc[d]) + nd;
      m_dc[d] = (t > 255) ? 8'hFF : t[7:0];
    end
  endtask

  task automatic compare();
    for (int d = 0; d < 2; d++) begin
      bit eb;
      eb = !rst && (mq[2*d].size() > 0 || mq[2*d+1].size() > 0
                    || m_we[d]);
      chk($sformatf("u%0d.oWE", d), we[d], m_we[d]);
      chk($sformatf("u%0d.oAddr", d), ad[d], m_ad[d]);
      chk($sformatf("u%0d.oData", d), dt[d], m_dt[d]);
      chk($sformatf("u%0d.oRdData", d), rd[d], m_rd[d]);
      chk($sformatf("u%0d.oDropCount", d), dc[d], m_dc[d]);
      chk($sformatf("u%0d.oHostReady", d), hr[d],
          !rst && mq[2*d].size() < FD);
      chk($sformatf("u%0d.oSeqReady", d), sr[d],
          !rst && mq[2*d+1].size() < FD);
      chk($sformatf("u%0d.oBusy", d), busy[d], eb);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    hv = 0; sv = 0; ce = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
  endtask

  initial begin
    logic [4:0] order [$];
    logic [4:0] exp_order [6];
    int got;
    exp_order = '{5'd1, 5'd4, 5'd2, 5'd5, 5'd3, 5'd6};

    // Reset state
    do_reset();
    cycle();
    chk("rst_we", we[0], 1'b0);
    chk("rst_drop", dc[0], 8'h00);
    chk("rst_hready", hr[0], 1'b1);

    // Single write: minimum latency and readback
    hv = 1; ha = 5'h01; hd = 8'h1C;
    cycle();
    chk("lat_we_n1", we[0], 1'b0);
    hv = 0; ce = 1;
    cycle();
    chk("lat_we_n2", we[0], 1'b1);
    chk("lat_addr", ad[0], 5'h01);
    chk("lat_data", dt[0], 8'h1C);
    ce = 0; rda = 5'h01;
    cycle();
    chk("lat_we_n3", we[0], 1'b0);
    chk("lat_hold_data", dt[0], 8'h1C);
    cycle();
    chk("readback", rd[0], 8'h1C);
    rda = 5'h1A;
    cycle();
    cycle();
    chk("readback_hi", rd[0], 8'h00);

    // Drops on both ports, then saturation
    hv = 1; sv = 1; ha = 5'h1B; sa = 5'h1B;
    cycle();
    chk("drop2", dc[0], 8'd2);
    chk("drop_no_we", we[0], 1'b0);
    for (int i = 0; i < 149; i++) cycle();
    chk("drop_sat", dc[0], 8'd255);
    idle();
    cycle();

    // FIFO full with depth 4, then one pop
    do_reset();
    hv = 1;
    for (int i = 0; i < FD; i++) begin
      ha = 5'(i + 2); hd = 8'(i + 8'h40);
      cycle();
    end
    chk("full_ready", hr[0], 1'b0);
    ha = 5'h10;
    cycle();
    chk("full_ready_hold", hr[0], 1'b0);
    ce = 1;
    cycle();
    chk("ready_after_pop", hr[0], 1'b1);
    idle();
    for (int i = 0; i < 12; i++) begin
      ce = (i % 2 == 0);
      cycle();
    end

    // Round robin H,S,H,S,H,S and busy falls after sixth issue
    do_reset();
    hv = 1; sv = 1;
    for (int i = 0; i < 3; i++) begin
      ha = 5'(i + 1); hd = 8'(i + 8'hA0);
      sa = 5'(i + 4); sd = 8'(i + 8'hB0);
      cycle();
    end
    idle();
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      ce = (c % 4 == 0);
      cycle();
      if (we[0]) order.push_back(ad[0]);
      got = order.size();
    end
    chk("rr_busy_last_we", busy[0], 1'b1);
    ce = 0;
    cycle();
    chk("rr_busy_fall", busy[0], 1'b0);
    chk("rr_count", got, 6);
    for (int i = 0; i < 6; i++)
      if (i < order.size())
        chk($sformatf("rr_order%0d", i), order[i], exp_order[i]);

    // Host priority: sequencer queued first, host still wins
    do_reset();
    sv = 1; sa = 5'h07; sd = 8'h77;
    cycle();
    sv = 0; hv = 1; ha = 5'h08; hd = 8'h88;
    cycle();
    hv = 0; ce = 1;
    cycle();
    chk("hp_we", we[1], 1'b1);
    chk("hp_addr", ad[1], 5'h08);
    ce = 1;
    cycle();
    chk("hp_second", ad[1], 5'h07);
    idle();
    cycle();

    // Reset with queued entries and clkEn in the same cycle
    do_reset();
    hv = 1; ha = 5'h03; hd = 8'h5A;
    cycle();
    hv = 0; ce = 1; rda = 5'h03;
    cycle();
    ce = 0;
    cycle();
    cycle();
    chk("pre_rst_shadow", rd[0], 8'h5A);
    hv = 1;
    for (int i = 0; i < 3; i++) begin
      ha = 5'(i + 10); hd = 8'(i + 1);
      cycle();
    end
    rst = 1; ce = 1;
    cycle();
    rst = 0; ce = 0; hv = 0;
    cycle();
    chk("rst_cancel_we", we[0], 1'b0);
    chk("rst_busy", busy[0], 1'b0);
    chk("rst_rel_hready", hr[0], 1'b1);
    chk("rst_rel_sready", sr[0], 1'b1);
    cycle();
    chk("rst_shadow", rd[0], 8'h00);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      hv = 1'($urandom % 2);
      sv = 1'($urandom % 2);
      ha = ($urandom % 8 == 0) ? 5'(25 + $urandom % 7)
                               : 5'($urandom % 25);
      sa = ($urandom % 8 == 0) ? 5'(25 + $urandom % 7)
                               : 5'($urandom % 25);
      hd = 8'($urandom);
      sd = 8'($urandom);
      ce = ($urandom % 3 == 0);
      rst = ($urandom % 250 == 0);
      rda = 5'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
